// File: rtl/brc_pkg.sv
// Shared types and decode helpers for the iterative branch comparator.
package brc_pkg;

    localparam int unsigned BR_OP_W = 3;

    typedef enum logic [BR_OP_W-1:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_RSV2 = 3'b010,
        BR_RSV3 = 3'b011,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // funct3 bit 1 selects the unsigned flavour (also covers the reserved 010/011 codes)
    function automatic logic br_is_signed(input br_op_e op);
        return ~op[1];
    endfunction

    function automatic logic br_taken(input br_op_e op, input logic less, input logic equal);
        logic taken;
        taken = 1'b0;
        case (op)
            BR_BEQ:           taken = equal;
            BR_BNE:           taken = ~equal;
            BR_BLT, BR_BLTU:  taken = less;
            BR_BGE, BR_BGEU:  taken = ~less;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/brc_iter_if.sv
// Request/result handshake bundle of the iterative branch comparator.
interface brc_iter_if
    import brc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic               i_flush;
    logic               i_valid;
    logic               o_ready;
    logic [WIDTH-1:0]   i_rs1_data;
    logic [WIDTH-1:0]   i_rs2_data;
    logic [BR_OP_W-1:0] i_br_op;
    logic               o_valid;
    logic               i_ready;
    logic               o_br_less;
    logic               o_br_equal;
    logic               o_br_taken;

    modport master (
        output i_flush, i_valid, i_rs1_data, i_rs2_data, i_br_op, i_ready,
        input  o_ready, o_valid, o_br_less, o_br_equal, o_br_taken
    );

    modport slave (
        input  i_flush, i_valid, i_rs1_data, i_rs2_data, i_br_op, i_ready,
        output o_ready, o_valid, o_br_less, o_br_equal, o_br_taken
    );
endinterface

// File: rtl/brc_chunk_cmp.sv
// One chunk of the magnitude compare; i_inv_msb flips the top bit so signed order maps onto unsigned order.
module brc_chunk_cmp #(
    parameter int unsigned CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] i_a,
    input  logic [CHUNK_W-1:0] i_b,
    input  logic               i_inv_msb,
    output logic               o_less_c,
    output logic               o_equal_c
);
    logic [CHUNK_W-1:0] msb_mask;
    logic [CHUNK_W-1:0] a_m;
    logic [CHUNK_W-1:0] b_m;

    always_comb begin
        msb_mask            = '0;
        msb_mask[CHUNK_W-1] = i_inv_msb;
        a_m                 = i_a ^ msb_mask;
        b_m                 = i_b ^ msb_mask;
    end

    assign o_less_c  = (a_m < b_m);
    assign o_equal_c = (a_m == b_m);
endmodule

// File: rtl/brc_iter.sv
// Iterative RV32I branch comparator: scans operands one chunk per cycle, MSB chunk first.
module brc_iter
    import brc_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CHUNK_W    = 8,
    parameter int unsigned EARLY_EXIT = 1
) (
    input logic       i_clk,
    input logic       i_reset,
    brc_iter_if.slave bus
);
    localparam int unsigned NCHUNK = (CHUNK_W == 0) ? 1 : WIDTH / CHUNK_W;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK_W < 1 || CHUNK_W > WIDTH || (WIDTH % CHUNK_W) != 0) begin : g_bad_chunk
        $error("brc_iter: CHUNK_W must divide WIDTH and lie in 1..WIDTH");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    br_op_e             op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               found_q, found_d;
    logic               lacc_q, lacc_d;
    logic               valid_q, valid_d;
    logic               less_q, less_d;
    logic               equal_q, equal_d;
    logic               taken_q, taken_d;

    logic [CHUNK_W-1:0] a_sel;
    logic [CHUNK_W-1:0] b_sel;
    logic               inv_msb;
    logic               c_less;
    logic               c_equal;
    logic               hit;
    logic               fin_less;
    logic               fin_equal;

    // Chunk select by the current scan index
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sel = a_q[i*CHUNK_W +: CHUNK_W];
                b_sel = b_q[i*CHUNK_W +: CHUNK_W];
            end
        end
        inv_msb = br_is_signed(op_q) && (idx_q == IDX_W'(NCHUNK - 1));
    end

    brc_chunk_cmp #(
        .CHUNK_W (CHUNK_W)
    ) u_chunk_cmp (
        .i_a       (a_sel),
        .i_b       (b_sel),
        .i_inv_msb (inv_msb),
        .o_less_c  (c_less),
        .o_equal_c (c_equal)
    );

    // Next-state and result update
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        idx_d     = idx_q;
        found_d   = found_q;
        lacc_d    = lacc_q;
        valid_d   = valid_q;
        less_d    = less_q;
        equal_d   = equal_q;
        taken_d   = taken_q;
        hit       = ~found_q & ~c_equal;
        fin_less  = found_q ? lacc_q : c_less;
        fin_equal = ~found_q & c_equal;

        if (bus.i_flush) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        a_d     = bus.i_rs1_data;
                        b_d     = bus.i_rs2_data;
                        op_d    = br_op_e'(bus.i_br_op);
                        idx_d   = IDX_W'(NCHUNK - 1);
                        found_d = 1'b0;
                        lacc_d  = 1'b0;
                        state_d = ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (hit) begin
                        found_d = 1'b1;
                        lacc_d  = c_less;
                    end
                    if ((EARLY_EXIT != 0 && hit) || idx_q == '0) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        less_d  = fin_less;
                        equal_d = fin_equal;
                        taken_d = br_taken(op_q, fin_less, fin_equal);
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.i_ready) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= BR_BEQ;
            idx_q   <= '0;
            found_q <= 1'b0;
            lacc_q  <= 1'b0;
            valid_q <= 1'b0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            lacc_q  <= lacc_d;
            valid_q <= valid_d;
            less_q  <= less_d;
            equal_q <= equal_d;
            taken_q <= taken_d;
        end
    end

    // Ready must drop the instant reset asserts, hence the reset term
    assign bus.o_ready    = (state_q == ST_IDLE) & ~i_reset;
    assign bus.o_valid    = valid_q;
    assign bus.o_br_less  = less_q;
    assign bus.o_br_equal = equal_q;
    assign bus.o_br_taken = taken_q;
endmodule

// File: doc/brc_iter.md
BRC_ITER -- requirements
Module: brc_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter CHUNK_W, default 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK_W.
REQ-003 Parameter EARLY_EXIT, default 1; 1 = finish at first differing chunk, 0 = always scan all NCHUNK chunks.
REQ-004 i_clk  in  1  sole clock, rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_flush  in  1  synchronous abort of any in-flight compare.
REQ-007 i_valid  in  1  request valid.
REQ-008 o_ready  out  1  block can accept a request.
REQ-009 i_rs1_data  in  WIDTH  operand A.
REQ-010 i_rs2_data  in  WIDTH  operand B.
REQ-011 i_br_op  in  3  RV32I branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-012 o_valid  out  1  result valid.
REQ-013 i_ready  in  1  consumer accepts result.
REQ-014 o_br_less  out  1  A < B, signed or unsigned per op.
REQ-015 o_br_equal  out  1  A == B.
REQ-016 o_br_taken  out  1  branch decision for i_br_op.

Function
REQ-017 FSM states IDLE, CMP, DONE; o_ready SHALL be 1 only in IDLE while i_reset is low.
REQ-018 IDLE: i_valid=1 and i_flush=0 SHALL capture operands and op, set chunk index to NCHUNK-1 and move to CMP.
REQ-019 Signedness: i_br_op[1]=1 unsigned, else signed; signed compares SHALL invert bit WIDTH-1 of both operands in the MSB chunk only.
REQ-020 CMP: each cycle SHALL compare one chunk, MSB chunk first, descending index.
REQ-021 First differing chunk SHALL latch less = (A chunk < B chunk), equal = 0.
REQ-022 EARLY_EXIT=1: first difference SHALL move to DONE on the same edge; EARLY_EXIT=0: the latched result SHALL be held and the scan SHALL continue to chunk 0.
REQ-023 Chunk 0 processed with no difference SHALL latch equal = 1, less = 0, then DONE.
REQ-024 Latency, counting the accept edge as 0: o_valid SHALL rise after edge k, where k = NCHUNK (no difference, or EARLY_EXIT=0) or k = position of the first differing chunk from the MSB, starting at 1.
REQ-025 taken: BEQ=equal, BNE=~equal, BLT/BLTU=less, BGE/BGEU=~less; funct3 010/011 SHALL give taken=0 with less/equal still computed unsigned.
REQ-026 DONE: o_valid=1; outputs SHALL hold stable until i_valid-independent i_ready=1, then IDLE on that edge.
REQ-027 i_valid SHALL be ignored outside IDLE; back-to-back throughput is one request per (k+2) cycles.
REQ-028 o_br_less/o_br_equal/o_br_taken SHALL be registered and keep the last result while not in DONE.
REQ-029 i_flush=1 in any state SHALL force IDLE on the next edge with o_valid=0 and no capture, including when i_valid=1 in the same cycle; result registers are unchanged.
REQ-030 CHUNK_W=WIDTH SHALL yield a one-cycle CMP (k=1).
REQ-031 Elaboration SHALL fail unless 1 <= CHUNK_W <= WIDTH and WIDTH % CHUNK_W == 0.

Reset
REQ-032 i_reset=1 SHALL immediately force IDLE, o_valid=0, o_ready=0, o_br_less=0, o_br_equal=0, o_br_taken=0, chunk index 0, operand registers 0.
REQ-033 Reset mid-CMP or mid-DONE SHALL discard the request; the first request after deassertion SHALL behave as from power-up.

Structure
REQ-034 Shared package brc_pkg SHALL hold the br_op enum (funct3 codes), the FSM state enum and the signedness/taken decode function.
REQ-035 One combinational sub-module brc_chunk_cmp (CHUNK_W-wide less/equal, optional MSB invert) SHALL be instantiated once and muxed by chunk index.

Verification (WIDTH=32, CHUNK_W=8 unless stated)
REQ-036 A=B=0x00000005, BEQ -> o_valid after edge 4; equal=1, less=0, taken=1.
REQ-037 A=0xFFFFFFFF, B=0x00000001, BLT, EARLY_EXIT=1 -> o_valid after edge 1, less=1, taken=1; same operands BLTU -> less=0, taken=0.
REQ-038 A=0x80000000, B=0x7FFFFFFF, BGE -> less=1, taken=0; BGEU -> less=0, taken=1; EARLY_EXIT=0 -> both after edge 4 with the same results.
REQ-039 A=0x10, B=0x20, BNE, then i_ready=0 for 5 cycles -> o_valid=1 after edge 4; taken=1; outputs stable and o_ready=0 throughout; i_valid pulses ignored.
REQ-040 Flush asserted 2 cycles into CMP, with i_valid=1 in the same cycle -> IDLE next edge; no o_valid; no capture; prior result retained.
REQ-041 Async i_reset pulse mid-CMP -> all outputs 0 immediately; the next BEQ request completes normally.
